threshold_monitor: RTL and testbench
====================================

# threshold_monitor

Downstream consumer of the 10-bit magnitude comparator's `greaterthan` flag. It filters the raw A > B result through a persistence/release state machine and raises a debounced `alarm` only after the comparison has held for a programmable number of qualified samples. It also keeps a sticky alarm latch and a saturating count of alarm episodes. It sits between the combinational comparator and whatever control or status logic reacts to threshold crossings.

## Interface
- `PERSIST`, default 4: consecutive valid samples with `greaterthan`=1 needed to assert `alarm`; legal range 1..255.
- `RELEASE`, default 4: consecutive valid samples with `greaterthan`=0 needed to deassert `alarm`; legal range 1..255.
- `CNT_W`, default 8: width of `event_count`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `greaterthan`  in  1  comparator result (A > B); sampled only when `sample_valid`=1.
- `sample_valid`  in  1  qualifies `greaterthan` for this cycle.
- `clear_sticky`  in  1  clears `sticky` on the next edge.
- `alarm`  out  1  debounced, registered alarm level.
- `alarm_rise`  out  1  one-cycle pulse on each 0->1 transition of `alarm`.
- `sticky`  out  1  set on any alarm rise; held until `clear_sticky` or `reset`.
- `event_count`  out  CNT_W  number of alarm rises since reset; saturating.
- `state`  out  2  FSM state for debug: 0 IDLE, 1 PENDING, 2 ALARM, 3 RELEASING.

## Operation
- Internal run counter `run` is wide enough for max(PERSIST, RELEASE).
- On cycles with `sample_valid`=0, the FSM and `run` hold. `alarm` holds. `alarm_rise` is 0.
- The FSM acts only on valid samples:
  - IDLE: gt=1 sets `run`=1. If PERSIST=1, go to ALARM; otherwise go to PENDING. gt=0 keeps `run`=0.
  - PENDING: gt=1 increments `run`; when `run` reaches PERSIST, go to ALARM. gt=0 returns to IDLE with `run`=0.
  - ALARM: gt=0 sets `run`=1. If RELEASE=1, go to IDLE; otherwise go to RELEASING. gt=1 stays in ALARM.
  - RELEASING: gt=0 increments `run`; when `run` reaches RELEASE, go to IDLE. gt=1 returns to ALARM with `run`=0.
- `alarm` is 1 in the ALARM and RELEASING states and 0 otherwise.
- A rise occurs only on a PENDING->ALARM or IDLE->ALARM transition. A RELEASING->ALARM transition is not a new event: no pulse, no count.
- On a rise: `alarm_rise`=1 for one cycle, `event_count` increments, and `sticky` is set.
- `event_count` saturates at 2^CNT_W-1 and never wraps.
- `clear_sticky` and a rise on the same edge: set wins, `sticky`=1.
- `clear_sticky` with no rise: `sticky`=0 on the next edge.

## Timing
- All outputs are registered. Nothing is combinational from the inputs.
- Assertion latency: `alarm`, `alarm_rise`, `sticky` and the incremented `event_count` become visible in the cycle after the edge that samples the PERSIST-th consecutive valid gt=1.
- Deassertion latency: `alarm` drops in the cycle after the edge that samples the RELEASE-th consecutive valid gt=0.
- Reset values after a `reset`=1 edge: state IDLE, `run`=0, `alarm`=0, `alarm_rise`=0, `sticky`=0, `event_count`=0. Reset has priority over every other input.
- Reset mid-ALARM: `alarm` drops on that edge with no pulse. The next episode requires a full PERSIST run again.
- The `greaterthan` input is assumed settled before the edge. The comparator is combinational and shares `clk` timing with the upstream operand registers.

## Test plan
- Reset, then PERSIST=4 with valid=1 and gt=1 for 4 cycles -> after the 4th edge: `alarm`=1, `alarm_rise`=1 for exactly one cycle, `event_count`=1, `sticky`=1, `state`=2.
- Valid gt sequence 1,1,1,0,1,1,1,1 -> `alarm` stays 0 through the 7th sample and asserts after the 8th; `event_count`=1.
- gt=1 held with valid pattern 1,0,1,0,1,1 -> `alarm` asserts after the 6th cycle (4th valid sample); `state` holds during invalid cycles.
- In ALARM with RELEASE=3, valid gt sequence 0,0,1,0,0,0 -> `alarm` remains 1 through the 5th sample and drops after the 6th. The 1 returns RELEASING to ALARM with no pulse; `event_count` is unchanged.
- CNT_W=2, five separate alarm episodes -> `event_count` sequence 1,2,3,3,3. `clear_sticky` asserted on the 5th rise edge -> `sticky`=1. `clear_sticky` alone afterwards -> `sticky`=0.
- `reset` pulsed while in ALARM with `event_count`=2 -> next cycle all outputs 0. Then 4 valid gt=1 samples -> `event_count`=1, single `alarm_rise`.

Source files
------------

// File: rtl/threshold_monitor.sv
// threshold_monitor: debounces a comparator greater-than flag into a registered alarm,
// with a sticky alarm latch and a saturating count of alarm episodes.
module threshold_monitor #(
    parameter int PERSIST = 4,
    parameter int RELEASE = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             greaterthan,
    input  logic             sample_valid,
    input  logic             clear_sticky,
    output logic             alarm,
    output logic             alarm_rise,
    output logic             sticky,
    output logic [CNT_W-1:0] event_count,
    output logic [1:0]       state
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PENDING   = 2'd1,
        ALARM     = 2'd2,
        RELEASING = 2'd3
    } state_t;
    localparam int RUN_MAX = (PERSIST > RELEASE) ? PERSIST : RELEASE;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);
    state_t           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d, run_inc;
    logic             alarm_q, alarm_d;
    logic             rise_q, rise_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign run_inc = run_q + RUN_W'(1);
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        rise_d  = 1'b0;
        if (sample_valid) begin
            case (state_q)
                IDLE: begin
                    run_d = greaterthan ? RUN_W'(1) : '0;
                    if (greaterthan) begin
                        state_d = (PERSIST == 1) ? ALARM : PENDING;
                        rise_d  = (PERSIST == 1);
                    end
                end
                PENDING: begin
                    if (!greaterthan) begin
                        state_d = IDLE;
                        run_d   = '0;
                    end else if (run_inc == RUN_W'(PERSIST)) begin
                        state_d = ALARM;
                        run_d   = '0;
                        rise_d  = 1'b1;
                    end else begin
                        run_d = run_inc;
                    end
                end
                ALARM: begin
                    if (!greaterthan) begin
                        state_d = (RELEASE == 1) ? IDLE : RELEASING;
                        run_d   = RUN_W'(1);
                    end
                end
                RELEASING: begin
                    // a single high sample cancels the release without counting a new episode
                    if (greaterthan) begin
                        state_d = ALARM;
                        run_d   = '0;
                    end else if (run_inc == RUN_W'(RELEASE)) begin
                        state_d = IDLE;
                        run_d   = '0;
                    end else begin
                        run_d = run_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    run_d   = '0;
                end
            endcase
        end
        alarm_d  = (state_d == ALARM) || (state_d == RELEASING);
        sticky_d = rise_d | (sticky_q & ~clear_sticky);
        cnt_d    = (rise_d && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            run_q    <= '0;
            alarm_q  <= 1'b0;
            rise_q   <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            alarm_q  <= alarm_d;
            rise_q   <= rise_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end
    assign alarm       = alarm_q;
    assign alarm_rise  = rise_q;
    assign sticky      = sticky_q;
    assign event_count = cnt_q;
    assign state       = state_q;
endmodule

// File: tb/tb_threshold_monitor.sv
// tb_threshold_monitor: two instances (PERSIST 4/RELEASE 3/CNT_W 8 and 1/1/2) on shared inputs,
// checked against directed expectations and a streak-counting reference model.
module tb_threshold_monitor;
    logic       clk = 1'b0;
    logic       rst = 1'b0, gt = 1'b0, vld = 1'b0, clr = 1'b0;
    logic       a_alarm, a_rise, a_sticky, b_alarm, b_rise, b_sticky;
    logic [1:0] a_state, b_state, b_cnt;
    logic [7:0] a_cnt;
    int         n_chk = 0, n_fail = 0;
    int         mp[2] = '{4, 1};
    int         mr[2] = '{3, 1};
    int         mmax[2] = '{255, 3};
    bit         m_alarm[2], m_rise[2], m_sticky[2];
    int         m_run[2], m_cnt[2];

    always #5 clk = ~clk;

    threshold_monitor #(.PERSIST(4), .RELEASE(3), .CNT_W(8)) dut_a (
        .clk(clk), .reset(rst), .greaterthan(gt), .sample_valid(vld), .clear_sticky(clr),
        .alarm(a_alarm), .alarm_rise(a_rise), .sticky(a_sticky), .event_count(a_cnt), .state(a_state)
    );
    threshold_monitor #(.PERSIST(1), .RELEASE(1), .CNT_W(2)) dut_b (
        .clk(clk), .reset(rst), .greaterthan(gt), .sample_valid(vld), .clear_sticky(clr),
        .alarm(b_alarm), .alarm_rise(b_rise), .sticky(b_sticky), .event_count(b_cnt), .state(b_state)
    );

    wire [12:0] obs_a = {a_alarm, a_rise, a_sticky, a_state, a_cnt};
    wire [12:0] obs_b = {b_alarm, b_rise, b_sticky, b_state, 6'd0, b_cnt};

    // Debug state follows from the alarm level and whether a streak is in progress.
    function automatic logic [12:0] exp_vec(input int i);
        logic [1:0] st;
        st = m_alarm[i] ? ((m_run[i] != 0) ? 2'd3 : 2'd2) : ((m_run[i] != 0) ? 2'd1 : 2'd0);
        return {m_alarm[i], m_rise[i], m_sticky[i], st, 8'(m_cnt[i])};
    endfunction

    task automatic cyc(input bit r, input bit g, input bit v, input bit c);
        rst = r; gt = g; vld = v; clr = c;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                m_alarm[i] = 0; m_rise[i] = 0; m_sticky[i] = 0; m_run[i] = 0; m_cnt[i] = 0;
            end else begin
                m_rise[i] = 0;
                if (v && !m_alarm[i]) begin
                    m_run[i] = g ? m_run[i] + 1 : 0;
                    if (m_run[i] >= mp[i]) begin
                        m_alarm[i] = 1; m_run[i] = 0; m_rise[i] = 1;
                    end
                end else if (v) begin
                    m_run[i] = g ? 0 : m_run[i] + 1;
                    if (m_run[i] >= mr[i]) begin
                        m_alarm[i] = 0; m_run[i] = 0;
                    end
                end
                m_sticky[i] = m_rise[i] | (m_sticky[i] & !c);
                if (m_rise[i] && m_cnt[i] < mmax[i]) m_cnt[i]++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        cyc(1, 1, 1, 0);
        n_chk++; if (obs_a !== 13'd0) begin n_fail++; $display("FAIL reset_a got=%h exp=0", obs_a); end
        n_chk++; if (obs_b !== 13'd0) begin n_fail++; $display("FAIL reset_b got=%h exp=0", obs_b); end
    endtask

    task automatic test_persist();
        cyc(1, 0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            cyc(0, 1, 1, 0);
            n_chk++; if (a_alarm !== 1'b0 || a_state !== 2'd1) begin n_fail++; $display("FAIL persist_early k=%0d alarm=%b state=%0d exp alarm=0 state=1", k, a_alarm, a_state); end
        end
        cyc(0, 1, 1, 0);
        n_chk++; if ({a_alarm, a_rise, a_sticky, a_state, a_cnt} !== {3'b111, 2'd2, 8'd1}) begin n_fail++; $display("FAIL persist_assert got=%h exp=%h", obs_a, {3'b111, 2'd2, 8'd1}); end
        cyc(0, 1, 1, 0);
        n_chk++; if (a_rise !== 1'b0 || a_alarm !== 1'b1 || a_cnt !== 8'd1) begin n_fail++; $display("FAIL persist_single_pulse rise=%b alarm=%b cnt=%0d exp 0 1 1", a_rise, a_alarm, a_cnt); end
    endtask

    task automatic test_interrupted();
        bit seq[8] = '{1, 1, 1, 0, 1, 1, 1, 1};
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            cyc(0, seq[k], 1, 0);
            n_chk++; if (a_alarm !== (k == 7)) begin n_fail++; $display("FAIL interrupted k=%0d alarm=%b exp=%b", k, a_alarm, k == 7); end
        end
        n_chk++; if (a_cnt !== 8'd1) begin n_fail++; $display("FAIL interrupted_cnt got=%0d exp=1", a_cnt); end
    endtask

    task automatic test_gaps();
        bit pat[6] = '{1, 0, 1, 0, 1, 1};
        logic [1:0] prev;
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            prev = a_state;
            cyc(0, 1, pat[k], 0);
            if (!pat[k]) begin
                n_chk++; if (a_state !== prev) begin n_fail++; $display("FAIL gaps_hold k=%0d state=%0d exp=%0d", k, a_state, prev); end
            end
            n_chk++; if (a_alarm !== (k == 5)) begin n_fail++; $display("FAIL gaps k=%0d alarm=%b exp=%b", k, a_alarm, k == 5); end
        end
    endtask

    task automatic test_release();
        bit seq[6] = '{0, 0, 1, 0, 0, 0};
        for (int k = 0; k < 6; k++) begin
            cyc(0, seq[k], 1, 0);
            n_chk++; if (a_alarm !== (k != 5) || a_rise !== 1'b0 || a_cnt !== 8'd1) begin n_fail++; $display("FAIL release k=%0d alarm=%b rise=%b cnt=%0d exp alarm=%b rise=0 cnt=1", k, a_alarm, a_rise, a_cnt, k != 5); end
        end
        n_chk++; if (a_state !== 2'd0) begin n_fail++; $display("FAIL release_state got=%0d exp=0", a_state); end
    endtask

    task automatic test_saturation();
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 1, 1, k == 4);
            n_chk++; if (b_rise !== 1'b1 || b_cnt !== 2'((k + 1 > 3) ? 3 : k + 1)) begin n_fail++; $display("FAIL sat k=%0d rise=%b cnt=%0d exp rise=1 cnt=%0d", k, b_rise, b_cnt, (k + 1 > 3) ? 3 : k + 1); end
            if (k == 4) begin
                n_chk++; if (b_sticky !== 1'b1) begin n_fail++; $display("FAIL sat_set_wins sticky=%b exp=1", b_sticky); end
            end
            cyc(0, 0, 1, 0);
        end
        cyc(0, 0, 0, 1);
        n_chk++; if (b_sticky !== 1'b0 || b_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_clear sticky=%b cnt=%0d exp 0 3", b_sticky, b_cnt); end
    endtask

    task automatic test_reset_mid_alarm();
        int rises = 0;
        cyc(1, 0, 0, 0);
        repeat (4) cyc(0, 1, 1, 0);
        repeat (3) cyc(0, 0, 1, 0);
        repeat (4) cyc(0, 1, 1, 0);
        n_chk++; if (a_alarm !== 1'b1 || a_cnt !== 8'd2) begin n_fail++; $display("FAIL midreset_pre alarm=%b cnt=%0d exp 1 2", a_alarm, a_cnt); end
        cyc(1, 1, 1, 0);
        n_chk++; if (obs_a !== 13'd0) begin n_fail++; $display("FAIL midreset_zero got=%h exp=0", obs_a); end
        for (int k = 0; k < 5; k++) begin
            cyc(0, 1, 1, 0);
            rises += a_rise;
        end
        n_chk++; if (rises != 1 || a_cnt !== 8'd1) begin n_fail++; $display("FAIL midreset_after rises=%0d cnt=%0d exp 1 1", rises, a_cnt); end
    endtask

    task automatic test_random();
        cyc(1, 0, 0, 0);
        for (int k = 0; k < 600; k++) begin
            cyc($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 15) == 0);
            n_chk++; if (obs_a !== exp_vec(0)) begin n_fail++; $display("FAIL random_a k=%0d got=%h exp=%h", k, obs_a, exp_vec(0)); end
            n_chk++; if (obs_b !== exp_vec(1)) begin n_fail++; $display("FAIL random_b k=%0d got=%h exp=%h", k, obs_b, exp_vec(1)); end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_persist();
        test_interrupted();
        test_gaps();
        test_release();
        test_saturation();
        test_reset_mid_alarm();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
